// File: rtl/la_checkpoint_monitor_if.sv
// Bus bundle for la_checkpoint_monitor: observation input, pattern table port,
// run configuration and result status. The tb/firmware side uses master, the monitor uses slave.
interface la_checkpoint_monitor_if #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 8,
  parameter int TIMEOUT_W = 24
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = AW + 1;

  // Strobe protocol: wr_en_i and start_i are single-cycle strobes sampled on
  // every rising edge with no back-pressure; done_o is a single-cycle pulse the
  // monitor raises on entry to PASS or FAIL, and pass_o/fail_o then hold the result.
  logic [WIDTH-1:0]     obs_i;
  logic [WIDTH-1:0]     mask_i;
  logic                 wr_en_i;
  logic [AW-1:0]        wr_addr_i;
  logic [WIDTH-1:0]     wr_data_i;
  logic [SW-1:0]        num_steps_i;
  logic [TIMEOUT_W-1:0] timeout_i;
  logic                 start_i;
  logic                 busy_o;
  logic                 pass_o;
  logic                 fail_o;
  logic                 done_o;
  logic [SW-1:0]        step_o;
  logic [SW-1:0]        fail_step_o;
  logic [1:0]           state_o;

  modport master (
    output obs_i, mask_i, wr_en_i, wr_addr_i, wr_data_i, num_steps_i, timeout_i, start_i,
    input  busy_o, pass_o, fail_o, done_o, step_o, fail_step_o, state_o
  );

  modport slave (
    input  obs_i, mask_i, wr_en_i, wr_addr_i, wr_data_i, num_steps_i, timeout_i, start_i,
    output busy_o, pass_o, fail_o, done_o, step_o, fail_step_o, state_o
  );
endinterface

// File: rtl/la_checkpoint_monitor.sv
// Checkpoint sequencer: confirms a programmed series of masked patterns appears
// in order on a synchronized observation bus, each held stable, within a per-step timeout.
module la_checkpoint_monitor #(
  parameter int WIDTH       = 16,
  parameter int DEPTH       = 8,
  parameter int TIMEOUT_W   = 24,
  parameter int SYNC_STAGES = 2,
  parameter int STABLE      = 4
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  la_checkpoint_monitor_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = AW + 1;
  localparam int CW = $clog2(STABLE + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_PASS  = 2'd2,
    ST_FAIL  = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [SW-1:0]        step_q, step_d;
  logic [SW-1:0]        n_q, n_d;
  logic [SW-1:0]        fail_step_q, fail_step_d;
  logic [TIMEOUT_W-1:0] tmo_lim_q, tmo_lim_d;
  logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
  logic [CW-1:0]        stable_q, stable_d;
  logic                 done_q, done_d;

  logic [WIDTH-1:0]     sync_q [SYNC_STAGES];
  logic [WIDTH-1:0]     tbl_q [DEPTH];
  logic [WIDTH-1:0]     obs_s;
  logic [WIDTH-1:0]     exp_pat;
  logic [SW-1:0]        n_clamp;
  logic                 match;
  logic                 tbl_we;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= bus.obs_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign obs_s = sync_q[SYNC_STAGES-1];

  // The table is plain storage with no reset; it is frozen while a run is armed.
  assign tbl_we = bus.wr_en_i && (state_q != ST_ARMED) && ({1'b0, bus.wr_addr_i} < SW'(DEPTH));

  always_ff @(posedge wb_clk_i) begin
    if (tbl_we) tbl_q[bus.wr_addr_i] <= bus.wr_data_i;
  end

  assign exp_pat = tbl_q[step_q[AW-1:0]];
  assign match   = ((obs_s ^ exp_pat) & bus.mask_i) == '0;
  assign n_clamp = (bus.num_steps_i > SW'(DEPTH)) ? SW'(DEPTH) : bus.num_steps_i;

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    n_d         = n_q;
    fail_step_d = fail_step_q;
    tmo_lim_d   = tmo_lim_q;
    tmo_d       = tmo_q;
    stable_d    = stable_q;
    done_d      = 1'b0;
    if (bus.start_i) begin
      // Start re-arms from any state; an aborted run never reports done.
      n_d       = n_clamp;
      tmo_lim_d = bus.timeout_i;
      step_d    = '0;
      stable_d  = '0;
      tmo_d     = '0;
      if (n_clamp != '0) begin
        state_d = ST_ARMED;
      end else begin
        state_d = ST_PASS;
        done_d  = 1'b1;
      end
    end else if (state_q == ST_ARMED) begin
      if (match && (stable_q == CW'(STABLE - 1))) begin
        // Acceptance takes priority over a timeout landing on the same edge.
        step_d   = step_q + SW'(1);
        stable_d = '0;
        tmo_d    = '0;
        if (step_q + SW'(1) == n_q) begin
          state_d = ST_PASS;
          done_d  = 1'b1;
        end
      end else begin
        stable_d = match ? stable_q + CW'(1) : '0;
        tmo_d    = tmo_q + TIMEOUT_W'(1);
        if ((tmo_lim_q != '0) && (tmo_q == tmo_lim_q - TIMEOUT_W'(1))) begin
          state_d     = ST_FAIL;
          fail_step_d = step_q;
          done_d      = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= ST_IDLE;
      step_q      <= '0;
      n_q         <= '0;
      fail_step_q <= '0;
      tmo_lim_q   <= '0;
      tmo_q       <= '0;
      stable_q    <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      n_q         <= n_d;
      fail_step_q <= fail_step_d;
      tmo_lim_q   <= tmo_lim_d;
      tmo_q       <= tmo_d;
      stable_q    <= stable_d;
      done_q      <= done_d;
    end
  end

  assign bus.busy_o      = (state_q == ST_ARMED);
  assign bus.pass_o      = (state_q == ST_PASS);
  assign bus.fail_o      = (state_q == ST_FAIL);
  assign bus.done_o      = done_q;
  assign bus.step_o      = step_q;
  assign bus.fail_step_o = fail_step_q;
  assign bus.state_o     = state_q;
endmodule

// File: tb/tb_la_checkpoint_monitor.sv
// Directed bench for la_checkpoint_monitor: inputs change and outputs are
// sampled on the falling edge, each scenario checks its own hand-computed results.
module tb_la_checkpoint_monitor;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   done_cnt;

  la_checkpoint_monitor_if #(.WIDTH(16), .DEPTH(8), .TIMEOUT_W(24)) bus ();

  la_checkpoint_monitor #(
    .WIDTH(16), .DEPTH(8), .TIMEOUT_W(24), .SYNC_STAGES(2), .STABLE(4)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.done_o === 1'b1) done_cnt <= done_cnt + 1;
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] addr, input logic [15:0] data);
    bus.wr_en_i   = 1'b1;
    bus.wr_addr_i = addr;
    bus.wr_data_i = data;
    tick(1);
    bus.wr_en_i   = 1'b0;
  endtask

  task automatic start(input logic [3:0] n, input logic [23:0] tmo);
    bus.num_steps_i = n;
    bus.timeout_i   = tmo;
    bus.start_i     = 1'b1;
    tick(1);
    bus.start_i     = 1'b0;
  endtask

  task automatic load_table3();
    wr(3'd0, 16'hAB40);
    wr(3'd1, 16'hAB41);
    wr(3'd2, 16'hAB51);
  endtask

  // scenarios
  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", bus.busy_o); end
    checks++; if (bus.pass_o !== 1'b0) begin errors++; $display("FAIL reset_pass got %0b exp 0", bus.pass_o); end
    checks++; if (bus.fail_o !== 1'b0) begin errors++; $display("FAIL reset_fail got %0b exp 0", bus.fail_o); end
    checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %0b exp 0", bus.done_o); end
    checks++; if (bus.step_o !== 4'd0) begin errors++; $display("FAIL reset_step got %0d exp 0", bus.step_o); end
    checks++; if (bus.fail_step_o !== 4'd0) begin errors++; $display("FAIL reset_fail_step got %0d exp 0", bus.fail_step_o); end
    checks++; if (bus.state_o !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", bus.state_o); end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_basic_pass();
    int d0;
    bus.mask_i = 16'hFFFF;
    bus.obs_i  = 16'h0000;
    load_table3();
    tick(3);
    d0 = done_cnt;
    start(4'd3, 24'd1000);
    checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL basic_busy got %0b exp 1", bus.busy_o); end
    bus.obs_i = 16'hAB40; tick(10);
    bus.obs_i = 16'hAB41; tick(10);
    bus.obs_i = 16'hAB51; tick(10);
    checks++; if (bus.pass_o !== 1'b1) begin errors++; $display("FAIL basic_pass got %0b exp 1", bus.pass_o); end
    checks++; if (bus.step_o !== 4'd3) begin errors++; $display("FAIL basic_step got %0d exp 3", bus.step_o); end
    checks++; if (bus.fail_o !== 1'b0) begin errors++; $display("FAIL basic_fail got %0b exp 0", bus.fail_o); end
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL basic_busy_end got %0b exp 0", bus.busy_o); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL basic_done_pulses got %0d exp 1", done_cnt - d0); end
  endtask

  task automatic test_glitch();
    bus.mask_i = 16'hFFFF;
    bus.obs_i  = 16'h0000;
    tick(3);
    start(4'd3, 24'd0);
    bus.obs_i = 16'hAB40; tick(10);
    checks++; if (bus.step_o !== 4'd1) begin errors++; $display("FAIL glitch_step0 got %0d exp 1", bus.step_o); end
    bus.obs_i = 16'hAB41; tick(3);
    bus.obs_i = 16'hAB40; tick(8);
    checks++; if (bus.step_o !== 4'd1) begin errors++; $display("FAIL glitch_reject got %0d exp 1", bus.step_o); end
    bus.obs_i = 16'hAB41; tick(4);
    bus.obs_i = 16'h0000; tick(8);
    checks++; if (bus.step_o !== 4'd2) begin errors++; $display("FAIL glitch_hold4 got %0d exp 2", bus.step_o); end
    checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL glitch_busy got %0b exp 1", bus.busy_o); end
  endtask

  task automatic test_timeout();
    int d0;
    int cnt;
    bit reached;
    bus.mask_i = 16'hFFFF;
    bus.obs_i  = 16'h0000;
    tick(3);
    d0 = done_cnt;
    start(4'd3, 24'd50);
    bus.obs_i = 16'hAB40;
    reached = 1'b0;
    for (int i = 0; i < 40 && !reached; i++) begin
      tick(1);
      if (bus.step_o === 4'd1) reached = 1'b1;
    end
    checks++; if (!reached) begin errors++; $display("FAIL timeout_reach_step1 got %0d exp 1", bus.step_o); end
    bus.obs_i = 16'h0000;
    cnt = 0;
    while (bus.fail_o !== 1'b1 && cnt < 200) begin
      tick(1);
      cnt++;
    end
    checks++; if (cnt !== 50) begin errors++; $display("FAIL timeout_latency got %0d exp 50", cnt); end
    tick(3);
    checks++; if (bus.fail_o !== 1'b1) begin errors++; $display("FAIL timeout_fail got %0b exp 1", bus.fail_o); end
    checks++; if (bus.fail_step_o !== 4'd1) begin errors++; $display("FAIL timeout_fail_step got %0d exp 1", bus.fail_step_o); end
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL timeout_busy got %0b exp 0", bus.busy_o); end
    checks++; if (bus.pass_o !== 1'b0) begin errors++; $display("FAIL timeout_pass got %0b exp 0", bus.pass_o); end
    checks++; if (bus.step_o !== 4'd1) begin errors++; $display("FAIL timeout_step_frozen got %0d exp 1", bus.step_o); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL timeout_done_pulses got %0d exp 1", done_cnt - d0); end
  endtask

  task automatic test_mask();
    bus.mask_i = 16'hFF00;
    wr(3'd0, 16'hAB00);
    bus.obs_i = 16'hAB7F;
    tick(3);
    start(4'd1, 24'd0);
    tick(8);
    checks++; if (bus.pass_o !== 1'b1) begin errors++; $display("FAIL mask_pass got %0b exp 1", bus.pass_o); end
    checks++; if (bus.step_o !== 4'd1) begin errors++; $display("FAIL mask_step got %0d exp 1", bus.step_o); end
    bus.mask_i = 16'hFFFF;
    start(4'd1, 24'd0);
    tick(8);
    checks++; if (bus.pass_o !== 1'b0) begin errors++; $display("FAIL mask_full_pass got %0b exp 0", bus.pass_o); end
    checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL mask_full_busy got %0b exp 1", bus.busy_o); end
  endtask

  task automatic test_zero_len();
    start(4'd0, 24'd0);
    checks++; if (bus.pass_o !== 1'b1) begin errors++; $display("FAIL zero_pass got %0b exp 1", bus.pass_o); end
    checks++; if (bus.done_o !== 1'b1) begin errors++; $display("FAIL zero_done got %0b exp 1", bus.done_o); end
    tick(1);
    checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL zero_done_clear got %0b exp 0", bus.done_o); end
    checks++; if (bus.step_o !== 4'd0) begin errors++; $display("FAIL zero_step got %0d exp 0", bus.step_o); end
  endtask

  task automatic test_clamp();
    bus.mask_i = 16'hFFFF;
    for (int i = 0; i < 8; i++) wr(3'(i), 16'h1000 + 16'(i));
    bus.obs_i = 16'h0000;
    tick(3);
    start(4'd12, 24'd0);
    for (int i = 0; i < 7; i++) begin
      bus.obs_i = 16'h1000 + 16'(i);
      tick(8);
    end
    checks++; if (bus.step_o !== 4'd7) begin errors++; $display("FAIL clamp_step7 got %0d exp 7", bus.step_o); end
    checks++; if (bus.pass_o !== 1'b0) begin errors++; $display("FAIL clamp_early_pass got %0b exp 0", bus.pass_o); end
    bus.obs_i = 16'h1007;
    tick(8);
    checks++; if (bus.pass_o !== 1'b1) begin errors++; $display("FAIL clamp_pass got %0b exp 1", bus.pass_o); end
    checks++; if (bus.step_o !== 4'd8) begin errors++; $display("FAIL clamp_step8 got %0d exp 8", bus.step_o); end
  endtask

  task automatic test_back_to_back();
    bus.mask_i = 16'hFFFF;
    wr(3'd0, 16'h5555);
    wr(3'd1, 16'h5555);
    bus.obs_i = 16'h0000;
    tick(3);
    start(4'd2, 24'd0);
    bus.obs_i = 16'h5555;
    tick(5);
    checks++; if (bus.step_o !== 4'd0) begin errors++; $display("FAIL b2b_before_accept got %0d exp 0", bus.step_o); end
    tick(1);
    checks++; if (bus.step_o !== 4'd1) begin errors++; $display("FAIL b2b_accept0 got %0d exp 1", bus.step_o); end
    tick(3);
    checks++; if (bus.pass_o !== 1'b0) begin errors++; $display("FAIL b2b_fresh_window got %0b exp 0", bus.pass_o); end
    tick(1);
    checks++; if (bus.pass_o !== 1'b1) begin errors++; $display("FAIL b2b_pass got %0b exp 1", bus.pass_o); end
    checks++; if (bus.step_o !== 4'd2) begin errors++; $display("FAIL b2b_step got %0d exp 2", bus.step_o); end
  endtask

  task automatic test_abort_and_reset();
    int d0;
    bus.mask_i = 16'hFFFF;
    load_table3();
    bus.obs_i = 16'h0000;
    tick(3);
    start(4'd3, 24'd0);
    bus.obs_i = 16'hAB40; tick(10);
    bus.obs_i = 16'hAB41; tick(10);
    checks++; if (bus.step_o !== 4'd2) begin errors++; $display("FAIL abort_pre_step got %0d exp 2", bus.step_o); end
    d0 = done_cnt;
    start(4'd3, 24'd0);
    checks++; if (bus.step_o !== 4'd0) begin errors++; $display("FAIL abort_step got %0d exp 0", bus.step_o); end
    checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL abort_busy got %0b exp 1", bus.busy_o); end
    tick(5);
    checks++; if (done_cnt !== d0) begin errors++; $display("FAIL abort_no_done got %0d exp %0d", done_cnt, d0); end
    // table write while armed must be dropped
    wr(3'd0, 16'hCDCD);
    bus.obs_i = 16'hAB40; tick(10);
    checks++; if (bus.step_o !== 4'd1) begin errors++; $display("FAIL wr_armed_step got %0d exp 1", bus.step_o); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %0b exp 0", bus.busy_o); end
    checks++; if (bus.step_o !== 4'd0) begin errors++; $display("FAIL rst_mid_step got %0d exp 0", bus.step_o); end
    checks++; if (bus.pass_o !== 1'b0 || bus.fail_o !== 1'b0 || bus.done_o !== 1'b0) begin
      errors++; $display("FAIL rst_mid_flags got %0b%0b%0b exp 000", bus.pass_o, bus.fail_o, bus.done_o);
    end
    checks++; if (bus.state_o !== 2'd0) begin errors++; $display("FAIL rst_mid_state got %0d exp 0", bus.state_o); end
    tick(2);
    rst = 1'b0;
    bus.obs_i = 16'hAB41;
    tick(10);
    checks++; if (bus.busy_o !== 1'b0 || bus.step_o !== 4'd0) begin
      errors++; $display("FAIL rst_no_resume got busy %0b step %0d exp busy 0 step 0", bus.busy_o, bus.step_o);
    end
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    done_cnt        = 0;
    rst             = 1'b1;
    bus.obs_i       = '0;
    bus.mask_i      = 16'hFFFF;
    bus.wr_en_i     = 1'b0;
    bus.wr_addr_i   = '0;
    bus.wr_data_i   = '0;
    bus.num_steps_i = '0;
    bus.timeout_i   = '0;
    bus.start_i     = 1'b0;
    test_reset();
    test_basic_pass();
    test_glitch();
    test_timeout();
    test_mask();
    test_zero_len();
    test_clamp();
    test_back_to_back();
    test_abort_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/la_checkpoint_monitor.md
Name: la_checkpoint_monitor

Overview:
- Synthesizable on-chip checkpoint sequencer for the user project.
- Watches a WIDTH-bit observation bus, e.g. checkbits driven on mprj_io[31:16] by firmware.
- Confirms that a programmed sequence of up to DEPTH expected patterns appears in order, each held stable, within a per-step timeout.
- Reports pass/fail, the current step and the failing step so LA or Wishbone logic can read the result without a testbench monitor.

Parameters:
- WIDTH, 16: observation bus and pattern width.
- DEPTH, 8: maximum number of checkpoints stored.
- TIMEOUT_W, 24: width of the per-step timeout counter.
- SYNC_STAGES, 2: synchronizer flops on obs_i (minimum 2).
- STABLE, 4: consecutive matching cycles required to accept a checkpoint (minimum 1).

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  reset. Asynchronous, active-high.
- obs_i  in  WIDTH  observed bus, asynchronous to wb_clk_i.
- mask_i  in  WIDTH  compare mask; 1 = bit compared.
- wr_en_i  in  1  pattern table write strobe.
- wr_addr_i  in  $clog2(DEPTH)  table index.
- wr_data_i  in  WIDTH  expected pattern.
- num_steps_i  in  $clog2(DEPTH)+1  sequence length, sampled on start.
- timeout_i  in  TIMEOUT_W  per-step cycle limit, sampled on start; 0 = no timeout.
- start_i  in  1  one-cycle arm/re-arm pulse.
- busy_o  out  1  high in ARMED.
- pass_o  out  1  sticky pass.
- fail_o  out  1  sticky fail.
- done_o  out  1  one-cycle pulse on entry to PASS or FAIL.
- step_o  out  $clog2(DEPTH)+1  index of the checkpoint currently awaited; frozen at end.
- fail_step_o  out  $clog2(DEPTH)+1  step that timed out.

Behaviour:
- Reset:
  - State IDLE.
  - busy_o, pass_o, fail_o, done_o = 0; step_o, fail_step_o = 0.
  - Synchronizer flops = 0; stable and timeout counters = 0.
  - Pattern table is not reset and reads undefined until written.
- Table writes:
  - Accepted when wr_en_i = 1 in IDLE, PASS or FAIL; ignored in ARMED.
  - wr_addr_i >= DEPTH is ignored.
- Synchronizer: obs_s = obs_i delayed SYNC_STAGES cycles. All compares use obs_s.
- Match: (obs_s & mask_i) == (table[step] & mask_i).
- FSM states: IDLE, ARMED, PASS, FAIL.
- start_i in any state:
  - Latch n = min(num_steps_i, DEPTH) and timeout_i.
  - step = 0; clear both counters; clear pass_o and fail_o.
  - Next state: ARMED if n > 0; otherwise PASS, with done_o pulsing on the next cycle.
- ARMED, each cycle:
  - Match: stable_cnt increments; else stable_cnt = 0.
  - Acceptance: when stable_cnt reaches STABLE, i.e. STABLE consecutive matching cycles, the checkpoint is accepted on that edge. step increments, stable_cnt and tmo_cnt clear, and the next compare uses the new entry on the following cycle.
  - Acceptance of step n-1 moves to PASS. pass_o = 1, done_o pulses, step_o = n.
  - tmo_cnt increments every cycle without acceptance. If timeout_i != 0 and tmo_cnt reaches timeout_i - 1 without acceptance, move to FAIL: fail_o = 1, fail_step_o = step, done_o pulses.
- Simultaneous acceptance and timeout on the same edge: acceptance wins.
- Repeated identical consecutive patterns: the second entry needs a fresh STABLE-cycle window after the first is accepted. The bus need not change value.
- start_i in ARMED aborts and re-arms immediately. No done_o pulse is issued for the aborted run.
- PASS and FAIL hold until start_i or reset. busy_o = 0 in both.
- Asynchronous reset mid-run returns to the reset values on assertion. Nothing resumes after deassertion.
- Latency: from an obs_i change to acceptance is SYNC_STAGES + STABLE cycles.

Test Plan:
- Basic pass:
  - Stimulus: table = {AB40, AB41, AB51}, n = 3, mask = FFFF, timeout = 1000. Drive AB40, AB41, AB51, holding each 10 cycles.
  - Required: pass_o = 1, step_o = 3, one done_o pulse, fail_o = 0.
- Glitch rejection (STABLE = 4):
  - Stimulus: AB41 for 3 cycles, then AB40.
  - Required: step_o stays 1; a later 4-cycle hold of AB41 advances step_o to 2.
- Timeout:
  - Stimulus: table as above, timeout = 50; drive AB40, then hold 0000.
  - Required: fail_o = 1, fail_step_o = 1, busy_o = 0, done_o pulses exactly once, about 50 cycles after step 1 is entered.
- Masking and degenerate lengths:
  - Stimulus: mask = FF00, table[0] = AB00, n = 1, obs = AB7F.
  - Required: pass.
  - Stimulus: n = 0.
  - Required: pass_o on the cycle after start, with done_o pulsing.
  - Stimulus: n = 12 with DEPTH = 8.
  - Required: pass after 8 steps.
- Abort and reset:
  - Stimulus: start_i at step 2 in ARMED.
  - Required: step_o = 0, no done_o pulse.
  - Stimulus: wr_en_i during ARMED.
  - Required: table unchanged.
  - Stimulus: wb_rst_i asserted mid-run.
  - Required: all outputs 0 immediately.
